// File: rtl/chip8_timers.sv
// rtl/chip8_timers.sv - Chip-8 delay/sound timers with 60 Hz tick synchroniser and buzzer tone generator
module chip8_timers #(
    parameter int BOTH_EDGES = 1,
    parameter int TONE_HALF  = 56818,
    parameter int TONE_W     = 20
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       dt_we,
    input  logic       st_we,
    input  logic [7:0] wdata,
    output logic [7:0] dt_out,
    output logic [7:0] st_out,
    output logic       sound_on,
    output logic       buzzer,
    output logic       tick_pulse
);

    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

    logic              s1;
    logic              s2;
    logic              s3;
    logic [TONE_W-1:0] tone_cnt;

    // s1/s2 resolve metastability on the divider output; s3 is the edge-detect history
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    generate
        if (BOTH_EDGES != 0) begin : g_both_edges
            assign tick_pulse = s2 ^ s3;
        end else begin : g_rise_only
            assign tick_pulse = s2 & ~s3;
        end
    endgenerate

    // A CPU write takes priority over a coincident tick; both timers stick at zero
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            dt_out <= 8'd0;
        end else if (dt_we) begin
            dt_out <= wdata;
        end else if (tick_pulse && (dt_out != 8'd0)) begin
            dt_out <= dt_out - 8'd1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            st_out <= 8'd0;
        end else if (st_we) begin
            st_out <= wdata;
        end else if (tick_pulse && (st_out != 8'd0)) begin
            st_out <= st_out - 8'd1;
        end
    end

    assign sound_on = (st_out != 8'd0);

    // Phase runs freely while sounding, so reloading a nonzero ST keeps the tone continuous
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            tone_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (!sound_on) begin
            tone_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            buzzer   <= ~buzzer;
        end else begin
            tone_cnt <= tone_cnt + TONE_W'(1);
        end
    end

endmodule

// File: tb/tb_chip8_timers.sv
// tb/tb_chip8_timers.sv - self-checking bench for chip8_timers (both-edge and rising-edge instances)
module tb_chip8_timers;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       tick_in = 1'b0;
    logic       dt_we = 1'b0;
    logic       st_we = 1'b0;
    logic [7:0] wdata = 8'd0;

    logic [7:0] dt_a, st_a, dt_b, st_b;
    logic       snd_a, snd_b, buz_a, buz_b, tp_a, tp_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state: index 0 = both-edge instance, 1 = rising-edge instance
    int m_dt[2];
    int m_st[2];
    int m_run[2];
    int m_half[2] = '{4, 5};
    bit hist[3];

    chip8_timers #(.BOTH_EDGES(1), .TONE_HALF(4), .TONE_W(3)) dut_a (
        .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .dt_we(dt_we), .st_we(st_we),
        .wdata(wdata), .dt_out(dt_a), .st_out(st_a), .sound_on(snd_a), .buzzer(buz_a),
        .tick_pulse(tp_a)
    );

    chip8_timers #(.BOTH_EDGES(0), .TONE_HALF(5), .TONE_W(3)) dut_b (
        .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .dt_we(dt_we), .st_we(st_we),
        .wdata(wdata), .dt_out(dt_b), .st_out(st_b), .sound_on(snd_b), .buzzer(buz_b),
        .tick_pulse(tp_b)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pulse(input int i);
        return (i == 0) ? (hist[1] ^ hist[2]) : (hist[1] & ~hist[2]);
    endfunction

    function automatic bit m_buzz(input int i);
        return ((m_run[i] / m_half[i]) % 2) == 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_dt[i] = 0; m_st[i] = 0; m_run[i] = 0;
        end
        hist = '{0, 0, 0};
    endtask

    task automatic model_step();
        if (reset) begin
            model_clear();
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit p, snd;
                p   = m_pulse(i);
                snd = (m_st[i] != 0);
                if (dt_we) m_dt[i] = wdata;
                else if (p && m_dt[i] > 0) m_dt[i]--;
                if (st_we) m_st[i] = wdata;
                else if (p && m_st[i] > 0) m_st[i]--;
                m_run[i] = snd ? m_run[i] + 1 : 0;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = tick_in;
        end
    endtask

    task automatic check_model();
        chk("dt_a", dt_a, m_dt[0]);
        chk("st_a", st_a, m_st[0]);
        chk("snd_a", snd_a, m_st[0] != 0);
        chk("buz_a", buz_a, m_buzz(0));
        chk("tp_a", tp_a, m_pulse(0));
        chk("dt_b", dt_b, m_dt[1]);
        chk("st_b", st_b, m_st[1]);
        chk("snd_b", snd_b, m_st[1] != 0);
        chk("buz_b", buz_b, m_buzz(1));
        chk("tp_b", tp_b, m_pulse(1));
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_step();
        #1;
        check_model();
    endtask

    task automatic wr(input bit d, input bit s, input logic [7:0] v);
        dt_we = d; st_we = s; wdata = v;
        cyc();
        dt_we = 1'b0; st_we = 1'b0;
    endtask

    task automatic toggle_tick();
        tick_in = ~tick_in;
        repeat (6) cyc();
    endtask

    typedef struct {
        bit         dt_w;
        bit         st_w;
        logic [7:0] val;
        int         toggles;
        int         e_dt_a, e_st_a, e_dt_b, e_st_b;
    } row_t;

    row_t tbl[6];

    initial begin
        tbl[0] = '{1, 0, 8'h03, 0, 3, 0, 3, 0};
        tbl[1] = '{0, 0, 8'h00, 2, 1, 0, 2, 0};
        tbl[2] = '{0, 0, 8'h00, 3, 0, 0, 0, 0};
        tbl[3] = '{1, 1, 8'h10, 1, 15, 15, 16, 16};
        tbl[4] = '{0, 1, 8'h02, 2, 13, 0, 15, 1};
        tbl[5] = '{1, 0, 8'h00, 1, 0, 0, 0, 0};

        model_clear();
        cyc();
        chk("rst_dt", dt_a, 0);
        chk("rst_st", st_a, 0);
        chk("rst_buz", buz_a, 0);
        chk("rst_tp", tp_a, 0);
        cyc();
        reset = 1'b0;
        repeat (4) cyc();

        for (int r = 0; r < 6; r++) begin
            if (tbl[r].dt_w || tbl[r].st_w) wr(tbl[r].dt_w, tbl[r].st_w, tbl[r].val);
            for (int t = 0; t < tbl[r].toggles; t++) toggle_tick();
            chk($sformatf("row%0d_dt_a", r), dt_a, tbl[r].e_dt_a);
            chk($sformatf("row%0d_st_a", r), st_a, tbl[r].e_st_a);
            chk($sformatf("row%0d_dt_b", r), dt_b, tbl[r].e_dt_b);
            chk($sformatf("row%0d_st_b", r), st_b, tbl[r].e_st_b);
        end

        // latency of a 0->1 transition: captured at edge k, pulse after k+1, gone after k+2
        toggle_tick();
        tick_in = 1'b1;
        cyc();
        chk("lat_k", tp_a, 0);
        cyc();
        chk("lat_k1_a", tp_a, 1);
        chk("lat_k1_b", tp_b, 1);
        cyc();
        chk("lat_k2", tp_a, 0);
        repeat (4) cyc();

        // write coincident with a tick pulse wins
        tick_in = 1'b0;
        cyc();
        cyc();
        chk("wbt_pulse", tp_a, 1);
        wr(1, 0, 8'h10);
        chk("wbt_dt", dt_a, 16);
        repeat (4) cyc();
        toggle_tick();
        chk("wbt_next", dt_a, 15);

        // tone with TONE_HALF=4
        wr(0, 1, 8'h02);
        chk("tone_snd", snd_a, 1);
        chk("tone_b0", buz_a, 0);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            chk($sformatf("tone_c%0d", c), buz_a, ((c / 4) % 2));
        end
        toggle_tick();
        toggle_tick();
        chk("tone_st0", st_a, 0);
        chk("tone_off_snd", snd_a, 0);
        chk("tone_off_buz", buz_a, 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            dt_we = ($urandom_range(0, 15) == 0);
            st_we = ($urandom_range(0, 15) == 0);
            wdata = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if ($urandom_range(0, 5) == 0) tick_in = ~tick_in;
            cyc();
        end
        dt_we = 1'b0; st_we = 1'b0;

        // asynchronous reset mid-tone, then release with tick_in high
        wr(1, 1, 8'h80);
        repeat (10) cyc();
        tick_in = 1'b1;
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        chk("arst_dt", dt_a, 0);
        chk("arst_st", st_a, 0);
        chk("arst_snd", snd_a, 0);
        chk("arst_buz", buz_a, 0);
        chk("arst_tp", tp_a, 0);
        chk("arst_st_b", st_b, 0);
        cyc();
        reset = 1'b0;
        repeat (20) cyc();
        chk("post_dt", dt_a, 0);
        chk("post_st", st_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
